serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//   Parametrised digit-serial adder/subtractor with add/sub mode and carry/borrow-in.
//   Processes DIGIT bits per cycle over WIDTH/DIGIT cycles.
//   Reports carry-out, signed overflow and zero.
//   Valid/ready handshakes on both sides; slots into datapaths where area matters more than latency.
// PARAMETERS
//   WIDTH  16  operand/result width in bits
//   DIGIT   4  bits processed per cycle; WIDTH % DIGIT == 0 and DIGIT >= 1, else $error at elaboration
// PORTS
//   clk        in   1      single clock, all state on posedge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block accepts operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin; 1: a-b-cin
//   out_valid  out  1      result valid, held until accepted
//   out_ready  in   1      downstream accepts result
//   result     out  WIDTH  sum/difference mod 2^WIDTH
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   overflow   out  1      two's-complement overflow
//   zero       out  1      result == 0
// BEHAVIOUR
//   N = WIDTH/DIGIT. FSM states: IDLE, CALC, DONE.
//   Reset (rst high at posedge): state=IDLE, digit counter=0.
//     out_valid, result, cout, overflow, zero all 0. in_ready=0 while rst is high.
//   IDLE: in_ready=1. On in_valid&&in_ready:
//     - capture a; capture b if sub=0, ~b if sub=1;
//     - carry = sub ? ~cin : cin;
//     - counter=0; go to CALC. Inputs are ignored after capture.
//   CALC: in_ready=0. Each cycle adds the low DIGIT bits of the A/B shift registers plus carry.
//     - Sum digit shifts into result from the MSB end; carry is updated.
//     - After digit N-1, go to DONE.
//   Flags:
//     - cout = final carry;
//     - overflow = carry into MSB XOR carry out of MSB;
//     - zero = (result==0).
//   Latency: out_valid rises exactly N cycles after the accepting edge
//     (N=1 when DIGIT==WIDTH).
//   DONE: out_valid=1. result and flags are stable until out_valid&&out_ready,
//     then go to IDLE at that edge.
//   No same-cycle result drain + operand accept: in_ready is 1 only in IDLE.
//     Minimum period is N+2 cycles per operation.
//   result, cout, overflow and zero are updated only on CALC->DONE.
//     Their value outside DONE is don't-care for consumers but must not be X.
//   rst during CALC or DONE: operation aborted, no out_valid, back to IDLE next cycle.
//   in_valid while not in IDLE: ignored, no capture.
// TESTING (WIDTH=8, DIGIT=4 unless noted)
//   a=7F b=01 cin=0 sub=0 -> result=80 cout=0 overflow=1 zero=0.
//     out_valid 2 cycles after accept.
//   a=FF b=01 cin=0 sub=0 -> result=00 cout=1 overflow=0 zero=1.
//   a=05 b=07 cin=0 sub=1 -> result=FE cout=0 overflow=0.
//     a=10 b=0F cin=1 sub=1 -> result=00 cout=1 zero=1.
//   Hold out_ready=0 for 5 cycles in DONE -> result/flags constant, in_ready=0.
//     Raise out_ready -> IDLE next cycle.
//   Assert rst 1 cycle mid-CALC -> out_valid never rises.
//     Next op a=12 b=34 sub=0 -> 46 correct.
//   Exhaustive random: 1000 ops with random a/b/cin/sub and random out_ready,
//     for DIGIT in {1,4,8} -> all outputs match the behavioural model
//     {cout,result}=a+(sub?~b:b)+(sub?~cin:cin).

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor with valid/ready handshakes.
// It takes WIDTH/DIGIT cycles per operation and handles DIGIT bits each cycle.
// Subtraction is computed as a + ~b + ~cin. For sub, cout=1 means no borrow.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_ready is high only in IDLE
//   a, b, cin, sub        operands, carry/borrow-in, mode (0 add, 1 sub)
//   out_valid/out_ready   result handshake; the result is held until accepted
//   result, cout,         sum or difference mod 2^WIDTH, carry out of the MSB,
//   overflow, zero        two's-complement overflow, result == 0
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int DSAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int N     = WIDTH / DSAFE;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;

  generate
    if ((DIGIT < 1) || (WIDTH % DSAFE != 0)) begin : g_bad_param
      $error("serial_addsub: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic             last;

  // Add one digit. b_sr already holds ~b in subtract mode.
  assign {dcarry, dsum} = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, carry};
  // The new sum digit enters at the MSB end. After N shifts the word is in order.
  assign res_nxt = WIDTH'({dsum, res_sr} >> DIGIT);
  assign last    = (cnt == CW'(N - 1));

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= sub ? ~b : b;
          carry <= sub ? ~cin : cin;
          cnt   <= '0;
        end
        CALC: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          carry  <= dcarry;
          res_sr <= res_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            result <= res_nxt;
            cout   <= dcarry;
            // Overflow occurs when the operand signs match and the result sign differs.
            // This is the same as carry into the MSB XOR carry out of the MSB.
            overflow <= (a_sr[DIGIT-1] == b_sr[DIGIT-1]) &&
                        (dsum[DIGIT-1] != a_sr[DIGIT-1]);
            zero     <= (res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH=8.
// Three instances use DIGIT = 1, 4 and 8. Index 1 (DIGIT=4) takes the directed vectors.
// In the random phase all three run the same operations.
module tb_serial_addsub;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   ir, ovld, co, ovf, zr;
  logic [W-1:0] res [3];
  int           checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ovld[0]), .out_ready(out_ready),
    .result(res[0]), .cout(co[0]), .overflow(ovf[0]), .zero(zr[0]));
  serial_addsub #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ovld[1]), .out_ready(out_ready),
    .result(res[1]), .cout(co[1]), .overflow(ovf[1]), .zero(zr[1]));
  serial_addsub #(.WIDTH(W), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ovld[2]), .out_ready(out_ready),
    .result(res[2]), .cout(co[2]), .overflow(ovf[2]), .zero(zr[2]));

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] r;
    logic       c, v, z;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Wait until the DIGIT=4 instance is idle, then present one operation.
  // The task returns on the negedge after the accepting posedge.
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic vs);
    int k = 0;
    @(negedge clk);
    while (!ir[1] && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("idle wait timeout", 0, 1);
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = ~vs;  // must be ignored after capture
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ovld[1] && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic run_vec(input int i);
    int lat;
    start_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub);
    wait_valid(lat);
    chk($sformatf("v%0d latency", i), lat, 2);
    chk($sformatf("v%0d result", i), res[1], vt[i].r);
    chk($sformatf("v%0d cout", i), co[1], vt[i].c);
    chk($sformatf("v%0d overflow", i), ovf[1], vt[i].v);
    chk($sformatf("v%0d zero", i), zr[1], vt[i].z);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d drained", i), ovld[1], 0);
  endtask

  initial begin
    int lat;
    int dg [3] = '{1, 4, 8};
    int nn [3] = '{8, 2, 1};

    //       a      b      cin   sub   result c     v     z
    vt[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[4] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vt[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vt[7] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    vt[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", ir[1], 0);
    chk("rst out_valid", ovld, 0);
    chk("rst result", res[1], 0);
    chk("rst flags", {co[1], ovf[1], zr[1]}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle in_ready", ir[1], 1);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Hold in DONE with back-pressure. A new in_valid must be ignored.
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_valid(lat);
    chk("hold latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      a = 8'h11; b = 8'h22; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d valid", k), ovld[1], 1);
      chk($sformatf("hold%0d in_ready", k), ir[1], 0);
      chk($sformatf("hold%0d result", k), res[1], 8'h80);
      chk($sformatf("hold%0d flags", k), {co[1], ovf[1], zr[1]}, 3'b010);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold release valid", ovld[1], 0);
    chk("hold release in_ready", ir[1], 1);

    // Reset mid-CALC aborts the operation.
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    rst = 1'b1;
    #1 chk("rst in_ready low", ir[1], 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("abort%0d no valid", k), ovld[1], 0);
      @(negedge clk);
    end
    for (int i = 4; i < 9; i++) run_vec(i);

    // Random operations on all three DIGIT sizes, with a random out_ready.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int op = 0; op < 1000; op++) begin
      logic [7:0] ra, rb, er;
      logic       rc, rs, ec, ev, ez;
      logic [8:0] s;
      int         sv, sa, sb, ci, k;
      logic [2:0] done, seen;
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      s  = {1'b0, ra} + {1'b0, (rs ? ~rb : rb)} + {8'h00, (rs ? ~rc : rc)};
      sa = $signed(ra); sb = $signed(rb); ci = rc;
      sv = rs ? (sa - sb - ci) : (sa + sb + ci);
      er = s[7:0]; ec = s[8]; ev = (sv > 127) || (sv < -128); ez = (er == 8'h00);
      k = 0;
      while (ir != 3'b111 && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) chk("rand idle timeout", 0, 1);
      a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      done = '0; seen = '0; k = 0;
      while (done != 3'b111 && k < 100) begin
        out_ready = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
          if (ovld[i] && !seen[i]) begin
            seen[i] = 1'b1;
            chk($sformatf("rand d%0d latency", dg[i]), k, nn[i]);
          end
          if (ovld[i] && out_ready && !done[i]) begin
            done[i] = 1'b1;
            chk($sformatf("rand d%0d result", dg[i]), res[i], er);
            chk($sformatf("rand d%0d cout", dg[i]), co[i], ec);
            chk($sformatf("rand d%0d overflow", dg[i]), ovf[i], ev);
            chk($sformatf("rand d%0d zero", dg[i]), zr[i], ez);
          end
        end
        @(negedge clk);
        k++;
      end
      out_ready = 1'b0;
      if (k >= 100) chk("rand drain timeout", 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
